// File: rtl/axi4_lite.sv
// AXI4-Lite channel bundle shared by managers and subordinates.
interface axi4_lite #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;

  modport manager (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport subordinate (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4_lite_subordinate.sv
// AXI4-Lite subordinate: decodes one address window and turns each bus transaction
// into a single held request on a native device port, with device timeout.
module axi4_lite_subordinate #(
  parameter int unsigned           WIDTH      = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [ADDR_WIDTH:0]   SIZE       = 4096,
  parameter int unsigned           TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axi4_lite.subordinate         axi_s,
  output logic                  dev_rd_en,
  output logic                  dev_wr_en,
  output logic [ADDR_WIDTH-1:0] dev_addr,
  output logic [WIDTH-1:0]      dev_wr_data,
  output logic [WIDTH/8-1:0]    dev_wr_strobe,
  input  logic [WIDTH-1:0]      dev_rd_data,
  input  logic                  dev_ack,
  input  logic                  dev_err
);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

  localparam int unsigned    CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StAwWait, StWWait, StDevWr, StDevRd, StBresp, StRresp
  } state_e;

  state_e                  state_q;
  logic                    prio_wr_q;
  logic [CntW-1:0]         cnt_q;
  logic                    aw_win_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [WIDTH-1:0]        wdata_q;
  logic [WIDTH/8-1:0]      wstrb_q;
  logic                    rd_en_q;
  logic                    wr_en_q;
  logic                    bvalid_q;
  logic                    rvalid_q;
  logic [1:0]              bresp_q;
  logic [1:0]              rresp_q;
  logic [WIDTH-1:0]        rdata_q;

  logic arready, awready, wready;
  logic ar_hs, aw_hs, w_hs;
  logic wr_go, wr_win;

  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return {1'b0, off} < SIZE;
  endfunction

  // Read/write arbitration lives only in idle; the wait states accept only the missing channel.
  always_comb begin
    arready = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    if (rst_n) begin
      case (state_q)
        StIdle: begin
          if (prio_wr_q) begin
            awready = 1'b1;
            wready  = 1'b1;
            arready = ~(axi_s.awvalid | axi_s.wvalid);
          end else begin
            arready = 1'b1;
            awready = ~axi_s.arvalid;
            wready  = ~axi_s.arvalid;
          end
        end
        StAwWait: awready = 1'b1;
        StWWait:  wready  = 1'b1;
        default: ;
      endcase
    end
  end

  assign ar_hs = axi_s.arvalid & arready;
  assign aw_hs = axi_s.awvalid & awready;
  assign w_hs  = axi_s.wvalid & wready;

  always_comb begin
    wr_go  = 1'b0;
    wr_win = aw_win_q;
    case (state_q)
      StIdle: begin
        wr_go  = aw_hs & w_hs;
        wr_win = in_window(axi_s.awaddr);
      end
      StAwWait: begin
        wr_go  = aw_hs;
        wr_win = in_window(axi_s.awaddr);
      end
      StWWait: wr_go = w_hs;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      prio_wr_q <= 1'b0;
      cnt_q     <= '0;
      aw_win_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      rresp_q   <= RespOkay;
      rdata_q   <= '0;
    end else begin
      if (ar_hs) begin
        addr_q <= axi_s.araddr - BASE_ADDR;
      end
      if (aw_hs) begin
        addr_q   <= axi_s.awaddr - BASE_ADDR;
        aw_win_q <= in_window(axi_s.awaddr);
      end
      if (w_hs) begin
        wdata_q <= axi_s.wdata;
        wstrb_q <= axi_s.wstrb;
      end

      unique case (state_q)
        StIdle: begin
          if (ar_hs) begin
            if (in_window(axi_s.araddr)) begin
              state_q <= StDevRd;
              rd_en_q <= 1'b1;
              cnt_q   <= '0;
            end else begin
              state_q  <= StRresp;
              rvalid_q <= 1'b1;
              rresp_q  <= RespDecerr;
              rdata_q  <= '0;
            end
          end else if (aw_hs && !w_hs) begin
            state_q <= StWWait;
          end else if (w_hs && !aw_hs) begin
            state_q <= StAwWait;
          end
        end
        StAwWait, StWWait: ;
        StDevRd: begin
          if (dev_ack) begin
            state_q  <= StRresp;
            rd_en_q  <= 1'b0;
            rvalid_q <= 1'b1;
            rresp_q  <= dev_err ? RespSlverr : RespOkay;
            rdata_q  <= dev_err ? '0 : dev_rd_data;
          end else if (cnt_q == CntLast) begin
            state_q  <= StRresp;
            rd_en_q  <= 1'b0;
            rvalid_q <= 1'b1;
            rresp_q  <= RespSlverr;
            rdata_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDevWr: begin
          if (dev_ack || cnt_q == CntLast) begin
            state_q  <= StBresp;
            wr_en_q  <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= (dev_ack && !dev_err) ? RespOkay : RespSlverr;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StBresp: begin
          if (axi_s.bready) begin
            state_q   <= StIdle;
            bvalid_q  <= 1'b0;
            prio_wr_q <= 1'b0;
          end
        end
        StRresp: begin
          if (axi_s.rready) begin
            state_q   <= StIdle;
            rvalid_q  <= 1'b0;
            prio_wr_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Write collection completes from idle or either wait state.
      if (wr_go) begin
        if (wr_win) begin
          state_q <= StDevWr;
          wr_en_q <= 1'b1;
          cnt_q   <= '0;
        end else begin
          state_q  <= StBresp;
          bvalid_q <= 1'b1;
          bresp_q  <= RespDecerr;
        end
      end
    end
  end

  assign axi_s.arready = arready;
  assign axi_s.awready = awready;
  assign axi_s.wready  = wready;
  assign axi_s.bvalid  = bvalid_q;
  assign axi_s.bresp   = bresp_q;
  assign axi_s.rvalid  = rvalid_q;
  assign axi_s.rresp   = rresp_q;
  assign axi_s.rdata   = rdata_q;

  assign dev_rd_en     = rd_en_q;
  assign dev_wr_en     = wr_en_q;
  assign dev_addr      = addr_q;
  assign dev_wr_data   = wdata_q;
  assign dev_wr_strobe = wstrb_q;

endmodule

// File: tb/tb_axi4_lite_subordinate.sv
// Directed bench for axi4_lite_subordinate: vector table of single transactions plus
// reset, arbitration and reset-mid-access sequences.
module tb_axi4_lite_subordinate;

  localparam int unsigned Tmo = 8;

  localparam logic [1:0] Okay   = 2'b00;
  localparam logic [1:0] Slverr = 2'b10;
  localparam logic [1:0] Decerr = 2'b11;

  logic        clk;
  logic        rst_n;
  logic        dev_rd_en;
  logic        dev_wr_en;
  logic [31:0] dev_addr;
  logic [31:0] dev_wr_data;
  logic [3:0]  dev_wr_strobe;
  logic [31:0] dev_rd_data;
  logic        dev_ack;
  logic        dev_err;

  int total;
  int bad;

  axi4_lite #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi4_lite_subordinate #(
    .WIDTH     (32),
    .ADDR_WIDTH(32),
    .BASE_ADDR (32'h1000),
    .SIZE      (33'd4096),
    .TIMEOUT   (Tmo)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .axi_s        (bus),
    .dev_rd_en    (dev_rd_en),
    .dev_wr_en    (dev_wr_en),
    .dev_addr     (dev_addr),
    .dev_wr_data  (dev_wr_data),
    .dev_wr_strobe(dev_wr_strobe),
    .dev_rd_data  (dev_rd_data),
    .dev_ack      (dev_ack),
    .dev_err      (dev_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_delay;
    int          w_delay;
    int          lat;
    bit          err;
    bit          noack;
    logic [31:0] rdata;
    int          rdy_delay;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    int          exp_en;
    int          exp_lat;
    logic [31:0] exp_daddr;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(bit wr, logic [31:0] addr, logic [31:0] wdata, logic [3:0] wstrb,
                              int aw_delay, int w_delay, int lat, bit err, bit noack,
                              logic [31:0] rdata, int rdy_delay, logic [1:0] exp_resp,
                              logic [31:0] exp_rdata, int exp_en, int exp_lat,
                              logic [31:0] exp_daddr);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
    v.aw_delay = aw_delay; v.w_delay = w_delay; v.lat = lat; v.err = err; v.noack = noack;
    v.rdata = rdata; v.rdy_delay = rdy_delay; v.exp_resp = exp_resp;
    v.exp_rdata = exp_rdata; v.exp_en = exp_en; v.exp_lat = exp_lat; v.exp_daddr = exp_daddr;
    return v;
  endfunction

  task automatic chk(input string nm, input int id, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, id, got, exp);
    end
  endtask

  task automatic idle_bus();
    bus.arvalid = 1'b0;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    bus.rready  = 1'b0;
    dev_ack     = 1'b0;
    dev_err     = 1'b0;
    dev_rd_data = 32'h0;
  endtask

  // Runs one transaction with a behavioural device and checks everything observed.
  task automatic run_vec(input vec_t v, input int id);
    bit          ar_pend, aw_pend, w_pend, done, unstable, saw_rd, saw_wr, rsp_v, rdy;
    int          en_cnt, hs_cyc, val_cyc, vld_cnt;
    logic [1:0]  cur_resp, first_resp;
    logic [31:0] cur_data, first_data, seen_addr, seen_wdata;
    logic [3:0]  seen_strb;
    ar_pend = !v.wr; aw_pend = v.wr; w_pend = v.wr;
    done = 0; unstable = 0; saw_rd = 0; saw_wr = 0;
    en_cnt = 0; hs_cyc = 0; val_cyc = -100; vld_cnt = 0;
    first_resp = 2'b01; first_data = 32'h0; cur_resp = 2'b01; cur_data = 32'h0;
    seen_addr = 32'hFFFF_FFFF; seen_wdata = 32'h0; seen_strb = 4'h0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge clk);
      bus.arvalid = ar_pend;
      bus.araddr  = v.addr;
      bus.awvalid = aw_pend && (cyc >= v.aw_delay);
      bus.awaddr  = v.addr;
      bus.wvalid  = w_pend && (cyc >= v.w_delay);
      bus.wdata   = v.wdata;
      bus.wstrb   = v.wstrb;
      if (dev_rd_en || dev_wr_en) begin
        saw_rd     = saw_rd | dev_rd_en;
        saw_wr     = saw_wr | dev_wr_en;
        seen_addr  = dev_addr;
        seen_wdata = dev_wr_data;
        seen_strb  = dev_wr_strobe;
        dev_ack     = !v.noack && (en_cnt == v.lat);
        dev_err     = dev_ack && v.err;
        dev_rd_data = dev_ack ? v.rdata : 32'h0;
        en_cnt++;
      end else begin
        dev_ack = 1'b0; dev_err = 1'b0; dev_rd_data = 32'h0;
      end
      bus.bready = v.wr && (vld_cnt >= v.rdy_delay);
      bus.rready = !v.wr && (vld_cnt >= v.rdy_delay);
      #1;
      if (bus.arvalid && bus.arready) begin ar_pend = 0; hs_cyc = cyc; end
      if (bus.awvalid && bus.awready) begin aw_pend = 0; hs_cyc = cyc; end
      if (bus.wvalid && bus.wready)   begin w_pend = 0;  hs_cyc = cyc; end
      rsp_v = v.wr ? bus.bvalid : bus.rvalid;
      rdy   = v.wr ? bus.bready : bus.rready;
      if (rsp_v) begin
        cur_resp = v.wr ? bus.bresp : bus.rresp;
        cur_data = v.wr ? 32'h0 : bus.rdata;
        if (vld_cnt == 0) begin
          val_cyc = cyc; first_resp = cur_resp; first_data = cur_data;
        end else if (cur_resp !== first_resp || cur_data !== first_data) begin
          unstable = 1;
        end
        vld_cnt++;
        if (rdy) done = 1;
      end
    end
    @(negedge clk);
    idle_bus();
    chk("completed", id, 32'(done), 32'd1);
    chk("resp", id, 32'(cur_resp), 32'(v.exp_resp));
    if (!v.wr) chk("rdata", id, cur_data, v.exp_rdata);
    chk("enable_cycles", id, en_cnt, v.exp_en);
    chk("resp_latency", id, val_cyc - hs_cyc, v.exp_lat);
    chk("resp_stable", id, 32'(unstable), 32'd0);
    if (v.exp_en > 0) begin
      chk("dev_addr", id, seen_addr, v.exp_daddr);
      chk("rd_en_seen", id, 32'(saw_rd), 32'(!v.wr));
      chk("wr_en_seen", id, 32'(saw_wr), 32'(v.wr));
      if (v.wr) begin
        chk("dev_wr_data", id, seen_wdata, v.wdata);
        chk("dev_wr_strobe", id, 32'(seen_strb), 32'(v.wstrb));
      end
    end
  endtask

  int   grants[4];
  int   ngrant;
  vec_t fresh;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle_bus();
    bus.araddr = 32'h1000; bus.awaddr = 32'h1000; bus.wdata = 32'h0; bus.wstrb = 4'h0;
    // Valids high during reset: readies must stay low.
    bus.arvalid = 1'b1; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    #12;
    chk("rst_arready", 0, 32'(bus.arready), 32'd0);
    chk("rst_awready", 0, 32'(bus.awready), 32'd0);
    chk("rst_wready", 0, 32'(bus.wready), 32'd0);
    chk("rst_valids", 0, {30'd0, bus.bvalid, bus.rvalid}, 32'd0);
    chk("rst_dev_en", 0, {30'd0, dev_rd_en, dev_wr_en}, 32'd0);
    chk("rst_resps", 0, {28'd0, bus.bresp, bus.rresp}, 32'd0);
    chk("rst_rdata", 0, bus.rdata, 32'd0);
    chk("rst_dev_addr", 0, dev_addr, 32'd0);
    chk("rst_dev_wr_data", 0, dev_wr_data, 32'd0);
    chk("rst_dev_wr_strobe", 0, 32'(dev_wr_strobe), 32'd0);
    @(negedge clk);
    idle_bus();
    rst_n = 1'b1;

    //           wr addr          wdata         strb  awd wd lat err na rdata       rdy
    //           resp    exp_rdata     en  lat daddr
    vecs[0] = mk(0, 32'h1008, 32'h0,        4'h0, 0, 0, 2, 0, 0, 32'hDEADBEEF, 2,
                 Okay,   32'hDEADBEEF, 3,   4,  32'h8);
    vecs[1] = mk(1, 32'h1010, 32'h12345678, 4'h5, 3, 0, 0, 0, 0, 32'h0,        0,
                 Okay,   32'h0,        1,   2,  32'h10);
    vecs[2] = mk(0, 32'h0FFC, 32'h0,        4'h0, 0, 0, 0, 0, 0, 32'h11111111, 0,
                 Decerr, 32'h0,        0,   1,  32'h0);
    vecs[3] = mk(1, 32'h2000, 32'h55AA55AA, 4'hF, 0, 0, 0, 0, 0, 32'h0,        0,
                 Decerr, 32'h0,        0,   1,  32'h0);
    vecs[4] = mk(0, 32'h1040, 32'h0,        4'h0, 0, 0, 1, 1, 0, 32'hCAFEF00D, 0,
                 Slverr, 32'h0,        2,   3,  32'h40);
    vecs[5] = mk(1, 32'h1FFC, 32'h0BADF00D, 4'h3, 0, 0, 0, 0, 1, 32'h0,        1,
                 Slverr, 32'h0,        Tmo, Tmo + 1, 32'hFFC);
    vecs[6] = mk(1, 32'h1000, 32'hA5A5A5A5, 4'h0, 0, 0, 0, 0, 0, 32'h0,        0,
                 Okay,   32'h0,        1,   2,  32'h0);
    vecs[7] = mk(0, 32'h1004, 32'h0,        4'h0, 0, 0, 0, 0, 1, 32'h77777777, 0,
                 Slverr, 32'h0,        Tmo, Tmo + 1, 32'h4);
    vecs[8] = mk(0, 32'h1FFC, 32'h0,        4'h0, 0, 0, 0, 0, 0, 32'h01234567, 0,
                 Okay,   32'h01234567, 1,   2,  32'hFFC);
    vecs[9] = mk(1, 32'h1020, 32'hFEEDFACE, 4'h8, 0, 2, 1, 1, 0, 32'h0,        0,
                 Slverr, 32'h0,        2,   3,  32'h20);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Every valid held high: grants must alternate, starting from read.
    for (int k = 0; k < 4; k++) grants[k] = -1;
    ngrant = 0;
    bus.araddr = 32'h1200; bus.awaddr = 32'h1204; bus.wdata = 32'h13572468; bus.wstrb = 4'hF;
    for (int cyc = 0; cyc < 80 && ngrant < 4; cyc++) begin
      @(negedge clk);
      bus.arvalid = 1'b1; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      bus.bready  = 1'b1; bus.rready  = 1'b1;
      dev_ack = dev_rd_en | dev_wr_en; dev_err = 1'b0; dev_rd_data = 32'h0;
      #1;
      if (bus.arready) begin
        grants[ngrant] = 0; ngrant++;
      end else if (bus.awready && bus.wready) begin
        grants[ngrant] = 1; ngrant++;
      end
    end
    @(negedge clk);
    bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      dev_ack = dev_rd_en | dev_wr_en;
      @(negedge clk);
    end
    idle_bus();
    chk("arb_count", 0, ngrant, 4);
    for (int k = 0; k < 4; k++) chk("arb_grant", k, grants[k], k % 2);
    chk("arb_drained", 0, {30'd0, bus.bvalid, bus.rvalid}, 32'd0);

    // Reset in the middle of a device read.
    @(negedge clk);
    bus.arvalid = 1'b1; bus.araddr = 32'h1100;
    @(negedge clk);
    bus.arvalid = 1'b0;
    #1;
    chk("mid_rd_en_before", 0, 32'(dev_rd_en), 32'd1);
    @(negedge clk);
    bus.arvalid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rd_en_reset", 0, 32'(dev_rd_en), 32'd0);
    chk("mid_rvalid_reset", 0, 32'(bus.rvalid), 32'd0);
    chk("mid_arready_reset", 0, 32'(bus.arready), 32'd0);
    @(negedge clk);
    bus.arvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rvalid_after", 0, 32'(bus.rvalid), 32'd0);
    fresh = mk(0, 32'h1100, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'h5A5A0001, 0,
               Okay, 32'h5A5A0001, 1, 2, 32'h100);
    run_vec(fresh, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi4_lite_subordinate.md
# axi4_lite_subordinate

AXI4-Lite subordinate endpoint that terminates bus transactions issued by `axi4_lite_manager` and converts them into single-outstanding requests on a simple native device port for memory or peripheral registers. It decodes one address window (`BASE_ADDR`, `SIZE`) and accepts AW and W in either order. It arbitrates reads against writes round-robin and returns OKAY, SLVERR (device error or timeout) or DECERR (outside the window). It sits between the system interconnect and a RAM, ROM or peripheral register block.

## Interface
- `WIDTH`, 32, data width (bits); must equal `rv32::XLEN`.
- `ADDR_WIDTH`, 32, address width.
- `BASE_ADDR`, 0, first byte address of the decoded window.
- `SIZE`, 4096, window size in bytes.
- `TIMEOUT`, `DEFAULT_AXI_TIMEOUT`, maximum cycles to wait for `dev_ack` before answering SLVERR.

- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `axi_s`  modport  —  `axi4_lite.subordinate`: drives awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp; samples the remaining channel signals.
- `dev_rd_en`  out  1  device read request, held until `dev_ack`.
- `dev_wr_en`  out  1  device write request, held until `dev_ack`.
- `dev_addr`  out  ADDR_WIDTH  byte offset: captured address minus `BASE_ADDR`.
- `dev_wr_data`  out  WIDTH  captured wdata.
- `dev_wr_strobe`  out  WIDTH/8  captured wstrb.
- `dev_rd_data`  in  WIDTH  read data, valid with `dev_ack`.
- `dev_ack`  in  1  request complete; may be asserted in the same cycle as the enable.
- `dev_err`  in  1  qualifies `dev_ack`: the access failed.

## Operation
**States**
- IDLE, AW_WAIT (W captured, AW missing), W_WAIT (AW captured, W missing), DEV_WR, DEV_RD, BRESP, RRESP.

**Arbitration** (IDLE only; `prio` register, reset = read)
- prio=read: arready=1, awready=wready=!arvalid.
- prio=write: awready=wready=1, arready=!(awvalid|wvalid).
- `prio` flips to the opposite type on each completed B or R handshake.

**Write collection**
- AW and W handshake in the same cycle -> DEV_WR.
- AW only -> W_WAIT: wready=1, all other readies 0.
- W only -> AW_WAIT: awready=1, all other readies 0.
- Missing channel arrives -> DEV_WR.

**Address decode and device access**
- Decode: in window iff `(addr - BASE_ADDR) < SIZE` (unsigned, ADDR_WIDTH bits).
- Out of window: device is never touched; go straight to BRESP/RRESP with DECERR.
- DEV_WR/DEV_RD: enable held; dev_addr/data/strobe held stable.
- `dev_ack` ends the access: response = dev_err ? SLVERR : OKAY; read data captured into rdata.
- Timeout counter clears on state entry. Reaching TIMEOUT without ack: drop enable, respond SLVERR.

**Responses**
- BRESP: bvalid=1 until bready. RRESP: rvalid=1 until rready.
- bresp/rresp/rdata stable while valid.
- rdata=0 on DECERR, SLVERR and timeout.
- On handshake -> IDLE.

**Misc**
- All-zero wstrb is still forwarded to the device.
- One transaction outstanding; every ready is 0 outside IDLE/AW_WAIT/W_WAIT.

## Timing
- Reset (async, while rst_n=0): state=IDLE, prio=read.
  - All readies, bvalid, rvalid, dev_rd_en, dev_wr_en = 0.
  - bresp=rresp=OKAY; rdata, dev_addr, dev_wr_data = 0; dev_wr_strobe = 0.
- Readies are combinational from state, prio and valids, gated by rst_n.
- Read, zero-wait device:
  - AR handshake cycle N; dev_rd_en high cycle N+1 with ack.
  - rvalid high from N+2; minimum AR->RVALID = 2 cycles.
- Write, zero-wait device: last of AW/W at cycle N; dev_wr_en at N+1; bvalid from N+2.
- DECERR: valid one cycle after the completing address/data handshake.
- Timeout: enable held exactly TIMEOUT cycles, then response valid the next cycle.
- Back-to-back: earliest next address handshake is the cycle after the B/R handshake.
- Reset mid-transaction: everything aborts immediately; no response is issued for the aborted transaction.

## Test plan
- **Read OK:** BASE_ADDR=0x1000, araddr=0x1008, dev_ack at 3rd DEV_RD cycle with dev_rd_data=0xDEADBEEF -> dev_addr=0x8; rvalid with rdata=0xDEADBEEF, rresp=OKAY; rready delayed 2 cycles -> rvalid/rdata held.
- **Write, W before AW:** wdata=0x12345678, wstrb=0b0101, then AW=0x1010 three cycles later -> single dev_wr_en pulse train with dev_addr=0x10 and matching data/strobe; bresp=OKAY.
- **Decode error:** araddr=0x0FFC and awaddr=0x2000 (SIZE=4096) -> DECERR, rdata=0, dev enables never asserted.
- **Device error / timeout:** dev_err=1 with ack -> SLVERR. No ack -> dev_wr_en high exactly TIMEOUT cycles, then bresp=SLVERR.
- **Arbitration:** arvalid, awvalid, wvalid held high continuously for 4 transactions -> grants read, write, read, write; no starvation.
- **Reset mid-op:** rst_n low during DEV_RD -> dev_rd_en and rvalid 0 immediately; after release, a fresh read completes OKAY.
